// File: rtl/fazyrv_bus_arb.sv
// -----------------------------------------------------------------------------
// fazyrv_bus_arb
//
// Shares a single Wishbone classic master port between the fazyrv core's
// instruction fetch port (imem) and its load/store port (dmem). One requester
// owns the bus at a time. The grant is held until the slave terminates the
// cycle (ack/err), the owner drops its strobe, or the optional watchdog fires.
// Every grant is followed by exactly one IDLE cycle before the next grant.
//
// Parameters
//   PRIO     "DMEM" : dmem wins when both request; "RR" : alternate on ties
//   TIMEOUT  0      : bus cycles without ack/err before an error is returned
//                     to the owner; 0 disables the watchdog
//   AW       32     : address width
//
// Ports
//   clk_i, rst_i                 clock (rising edge), synchronous reset (high)
//   imem_stb_i / imem_adr_i      fetch request and address
//   imem_dat_o / _ack_o / _err_o fetch read data, done, bus error/timeout
//   dmem_stb_i / _we_i / _be_i   data request, write enable, byte enables
//   dmem_adr_i / _dat_i          data address, write data
//   dmem_dat_o / _ack_o / _err_o data read data, done, bus error/timeout
//   wb_cyc_o .. wb_dat_o         registered Wishbone master outputs
//   wb_dat_i / _ack_i / _err_i   Wishbone slave response
// -----------------------------------------------------------------------------
module fazyrv_bus_arb #(
  parameter string PRIO    = "DMEM",
  parameter int    TIMEOUT = 0,
  parameter int    AW      = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          imem_stb_i,
  input  logic [AW-1:0] imem_adr_i,
  output logic [31:0]   imem_dat_o,
  output logic          imem_ack_o,
  output logic          imem_err_o,

  input  logic          dmem_stb_i,
  input  logic          dmem_we_i,
  input  logic [3:0]    dmem_be_i,
  input  logic [AW-1:0] dmem_adr_i,
  input  logic [31:0]   dmem_dat_i,
  output logic [31:0]   dmem_dat_o,
  output logic          dmem_ack_o,
  output logic          dmem_err_o,

  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [3:0]    wb_sel_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam bit PRIO_RR = (PRIO == "RR");

  // Counter wide enough to hold TIMEOUT; kept at one bit when disabled.
  localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_d;   // round-robin pointer: 1 = dmem was granted last
  logic            r_we;
  logic [3:0]      r_sel;
  logic [AW-1:0]   r_adr;
  logic [31:0]     r_dat;
  logic [CW-1:0]   r_cnt;

  logic            w_any_req;
  logic            w_pick_d;
  logic            w_gnt_stb;
  logic            w_bus_ack;
  logic            w_bus_err;
  logic            w_tmo;
  logic            w_err;
  logic            w_done;

  // ---------------------------------------------------------------------------
  // Arbitration decision (only used in IDLE)
  // ---------------------------------------------------------------------------
  assign w_any_req = imem_stb_i | dmem_stb_i;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_pick_d = 1'b0;
    if (dmem_stb_i && !imem_stb_i) begin
      w_pick_d = 1'b1;
    end else if (dmem_stb_i && imem_stb_i) begin
      // On a tie, RR grants whoever did not own the bus last.
      w_pick_d = PRIO_RR ? !r_last_d : 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Termination of the current grant
  // ---------------------------------------------------------------------------
  // Strobe of the current owner; low means the owner withdrew, and any slave
  // response arriving then is ignored.
  assign w_gnt_stb = ((r_state == S_GNT_I) && imem_stb_i) ||
                     ((r_state == S_GNT_D) && dmem_stb_i);

  // err beats ack when the slave raises both.
  assign w_bus_err = w_gnt_stb && wb_err_i;
  assign w_bus_ack = w_gnt_stb && wb_ack_i && !wb_err_i;

  // Watchdog fires in the TIMEOUT-th grant cycle unless the slave answers
  // in that very cycle.
  assign w_tmo  = (TIMEOUT > 0) && w_gnt_stb && (r_cnt == CNT_LAST) &&
                  !wb_ack_i && !wb_err_i;
  assign w_err  = w_bus_err || w_tmo;
  assign w_done = w_bus_ack || w_err;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_pick_d ? S_GNT_D : S_GNT_I;
        end
      end
      S_GNT_I, S_GNT_D: begin
        if (!w_gnt_stb || w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, RR pointer, captured bus request and watchdog counter
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous: rst_i is only looked at on the clock edge, so
  // it sits inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_cnt    <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the values from before this edge, independent of order.
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (w_any_req) begin
          // Capture the winner's request; it stays on the bus unchanged.
          r_last_d <= w_pick_d;
          r_cnt    <= '0;
          if (w_pick_d) begin
            r_we  <= dmem_we_i;
            r_sel <= dmem_be_i;
            r_adr <= dmem_adr_i;
            r_dat <= dmem_dat_i;
          end else begin
            r_we  <= 1'b0;
            r_sel <= 4'hF;
            r_adr <= imem_adr_i;
            r_dat <= '0;
          end
        end
      end else if (w_state_nxt == S_IDLE) begin
        r_we  <= 1'b0;
        r_sel <= '0;
        r_adr <= '0;
        r_dat <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wb_cyc_o = (r_state != S_IDLE);
  assign wb_stb_o = (r_state != S_IDLE);
  assign wb_we_o  = r_we;
  assign wb_sel_o = r_sel;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;

  // Read data is passed straight through; the ack qualifies it.
  assign imem_dat_o = wb_dat_i;
  assign dmem_dat_o = wb_dat_i;

  // A cycle being abandoned by reset reports nothing.
  assign imem_ack_o = !rst_i && (r_state == S_GNT_I) && w_bus_ack;
  assign imem_err_o = !rst_i && (r_state == S_GNT_I) && w_err;
  assign dmem_ack_o = !rst_i && (r_state == S_GNT_D) && w_bus_ack;
  assign dmem_err_o = !rst_i && (r_state == S_GNT_D) && w_err;

endmodule

// File: tb/tb_fazyrv_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_fazyrv_bus_arb
//
// Two arbiters side by side: u0 is round-robin with an 8-cycle watchdog, u1 is
// dmem-priority with no watchdog. Each has its own requesters and slave. A
// transaction-level model (who owns the bus, for how many cycles, who owned it
// last) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fazyrv_bus_arb;

  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT-facing signals, one slot per instance ----------------
  logic          rst       [2];
  logic          imem_stb  [2];
  logic [AW-1:0] imem_adr  [2];
  logic [31:0]   imem_dat  [2];
  logic          imem_ack  [2];
  logic          imem_err  [2];
  logic          dmem_stb  [2];
  logic          dmem_we   [2];
  logic [3:0]    dmem_be   [2];
  logic [AW-1:0] dmem_adr  [2];
  logic [31:0]   dmem_wdat [2];
  logic [31:0]   dmem_rdat [2];
  logic          dmem_ack  [2];
  logic          dmem_err  [2];
  logic          wb_cyc    [2];
  logic          wb_stb    [2];
  logic          wb_we     [2];
  logic [3:0]    wb_sel    [2];
  logic [AW-1:0] wb_adr    [2];
  logic [31:0]   wb_wdat   [2];
  logic [31:0]   wb_rdat   [2];
  logic          wb_ack    [2];
  logic          wb_err    [2];

  fazyrv_bus_arb #(.PRIO("RR"), .TIMEOUT(8), .AW(AW)) u0 (
    .clk_i(clk), .rst_i(rst[0]),
    .imem_stb_i(imem_stb[0]), .imem_adr_i(imem_adr[0]), .imem_dat_o(imem_dat[0]),
    .imem_ack_o(imem_ack[0]), .imem_err_o(imem_err[0]),
    .dmem_stb_i(dmem_stb[0]), .dmem_we_i(dmem_we[0]), .dmem_be_i(dmem_be[0]),
    .dmem_adr_i(dmem_adr[0]), .dmem_dat_i(dmem_wdat[0]), .dmem_dat_o(dmem_rdat[0]),
    .dmem_ack_o(dmem_ack[0]), .dmem_err_o(dmem_err[0]),
    .wb_cyc_o(wb_cyc[0]), .wb_stb_o(wb_stb[0]), .wb_we_o(wb_we[0]), .wb_sel_o(wb_sel[0]),
    .wb_adr_o(wb_adr[0]), .wb_dat_o(wb_wdat[0]), .wb_dat_i(wb_rdat[0]),
    .wb_ack_i(wb_ack[0]), .wb_err_i(wb_err[0])
  );

  fazyrv_bus_arb #(.PRIO("DMEM"), .TIMEOUT(0), .AW(AW)) u1 (
    .clk_i(clk), .rst_i(rst[1]),
    .imem_stb_i(imem_stb[1]), .imem_adr_i(imem_adr[1]), .imem_dat_o(imem_dat[1]),
    .imem_ack_o(imem_ack[1]), .imem_err_o(imem_err[1]),
    .dmem_stb_i(dmem_stb[1]), .dmem_we_i(dmem_we[1]), .dmem_be_i(dmem_be[1]),
    .dmem_adr_i(dmem_adr[1]), .dmem_dat_i(dmem_wdat[1]), .dmem_dat_o(dmem_rdat[1]),
    .dmem_ack_o(dmem_ack[1]), .dmem_err_o(dmem_err[1]),
    .wb_cyc_o(wb_cyc[1]), .wb_stb_o(wb_stb[1]), .wb_we_o(wb_we[1]), .wb_sel_o(wb_sel[1]),
    .wb_adr_o(wb_adr[1]), .wb_dat_o(wb_wdat[1]), .wb_dat_i(wb_rdat[1]),
    .wb_ack_i(wb_ack[1]), .wb_err_i(wb_err[1])
  );

  function automatic int timeout_of(int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic bit rr_of(int i);
    return (i == 0);
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- requesters ----------------
  typedef struct packed {
    logic        stb;
    logic        we;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  req_t req_i [2];
  req_t req_d [2];
  bit   reissue [2];   // requester immediately asks again after completion
  bit   rand_req [2];
  bit   rst_req [2];

  // ---------------- slave plan ----------------
  int ack_at [2];      // grant cycle (1-based) in which the slave acks, 0 = never
  int err_at [2];      // grant cycle in which the slave errs, 0 = never
  bit rand_slave [2];
  bit stray_ack [2];   // one-shot ack while the model says the bus is idle

  // ---------------- reference model ----------------
  // owner: 0 none, 1 imem, 2 dmem; age: completed cycles of the current grant.
  int          owner [2];
  int          age   [2];
  int          last  [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];

  function automatic req_t new_imem();
    req_t r;
    r.stb = 1'b1; r.we = 1'b0; r.be = 4'hF;
    r.adr = {$urandom_range(0, 255), 2'b00};
    r.dat = '0;
    return r;
  endfunction

  function automatic req_t new_dmem();
    req_t r;
    r.stb = 1'b1; r.we = 1'($urandom_range(0, 1)); r.be = 4'($urandom_range(1, 15));
    r.adr = 32'h8000_0000 | {$urandom_range(0, 255), 2'b00};
    r.dat = $urandom;
    return r;
  endfunction

  task automatic plan_slave(int i);
    int p;
    p = $urandom_range(0, 19);
    ack_at[i] = (i == 0) ? $urandom_range(1, 9) : $urandom_range(1, 4);
    err_at[i] = 0;
    if (p < 2) begin
      err_at[i] = ack_at[i];                 // ack and err together
    end else if (p < 4) begin
      err_at[i] = ack_at[i]; ack_at[i] = 0;  // err only
    end else if (p < 7 && i == 0) begin
      ack_at[i] = 0;                         // silent: watchdog must fire
    end
  endtask

  // Drive inputs for the coming cycle (called just after the rising edge).
  task automatic drive(int i);
    rst[i] = rst_req[i] || (rand_req[i] && $urandom_range(0, 599) == 0);
    if (rand_req[i]) begin
      if (!req_i[i].stb && $urandom_range(0, 9) < 4) req_i[i] = new_imem();
      if (!req_d[i].stb && $urandom_range(0, 9) < 4) req_d[i] = new_dmem();
      if (req_i[i].stb && $urandom_range(0, 49) == 0) req_i[i].stb = 1'b0;
      if (req_d[i].stb && $urandom_range(0, 49) == 0) req_d[i].stb = 1'b0;
      if (owner[i] == 0 && $urandom_range(0, 19) == 0) stray_ack[i] = 1'b1;
    end
    imem_stb[i]  = req_i[i].stb;
    imem_adr[i]  = req_i[i].adr;
    dmem_stb[i]  = req_d[i].stb;
    dmem_we[i]   = req_d[i].we;
    dmem_be[i]   = req_d[i].be;
    dmem_adr[i]  = req_d[i].adr;
    dmem_wdat[i] = req_d[i].dat;
    wb_rdat[i]   = rand_req[i] ? $urandom : 32'hDEAD_BEEF;
    if (owner[i] != 0) begin
      wb_ack[i] = (age[i] + 1 == ack_at[i]);
      wb_err[i] = (age[i] + 1 == err_at[i]);
    end else begin
      wb_ack[i] = stray_ack[i];
      wb_err[i] = 1'b0;
    end
    stray_ack[i] = 1'b0;
  endtask

  // Compare outputs with the model and advance it (called mid-cycle).
  task automatic step(int i);
    bit g_stb, e_ack, e_err, busy, both;
    int pick;
    string u;
    u = $sformatf("u%0d", i);
    busy  = (owner[i] != 0);
    g_stb = (owner[i] == 1) ? imem_stb[i] : (owner[i] == 2) ? dmem_stb[i] : 1'b0;
    e_ack = 1'b0;
    e_err = 1'b0;
    if (!rst[i] && busy && g_stb) begin
      if (wb_err[i])                                                  e_err = 1'b1;
      else if (wb_ack[i])                                             e_ack = 1'b1;
      else if (timeout_of(i) > 0 && age[i] == timeout_of(i) - 1)      e_err = 1'b1;
    end

    check({u, ".wb_cyc"}, 32'(wb_cyc[i]), 32'(busy));
    check({u, ".wb_stb"}, 32'(wb_stb[i]), 32'(busy));
    if (busy) begin
      check({u, ".wb_we"},  32'(wb_we[i]),  32'(m_we[i]));
      check({u, ".wb_sel"}, 32'(wb_sel[i]), 32'(m_sel[i]));
      check({u, ".wb_adr"}, wb_adr[i],      m_adr[i]);
      check({u, ".wb_dat"}, wb_wdat[i],     m_dat[i]);
    end
    check({u, ".imem_ack"}, 32'(imem_ack[i]), 32'(e_ack && owner[i] == 1));
    check({u, ".imem_err"}, 32'(imem_err[i]), 32'(e_err && owner[i] == 1));
    check({u, ".dmem_ack"}, 32'(dmem_ack[i]), 32'(e_ack && owner[i] == 2));
    check({u, ".dmem_err"}, 32'(dmem_err[i]), 32'(e_err && owner[i] == 2));
    check({u, ".imem_dat"}, imem_dat[i],  wb_rdat[i]);
    check({u, ".dmem_dat"}, dmem_rdat[i], wb_rdat[i]);

    if (rst[i]) begin
      owner[i] = 0; age[i] = 0; last[i] = 1;
      req_i[i].stb = 1'b0; req_d[i].stb = 1'b0;
    end else if (busy) begin
      if (e_ack || e_err) begin
        if (owner[i] == 1) req_i[i] = reissue[i] ? new_imem() : '0;
        else               req_d[i] = reissue[i] ? new_dmem() : '0;
        owner[i] = 0;
      end else if (!g_stb) begin
        owner[i] = 0;
      end else begin
        age[i]++;
      end
    end else if (imem_stb[i] || dmem_stb[i]) begin
      both = imem_stb[i] && dmem_stb[i];
      if (both) pick = rr_of(i) ? ((last[i] == 2) ? 1 : 2) : 2;
      else      pick = dmem_stb[i] ? 2 : 1;
      owner[i] = pick; age[i] = 0; last[i] = pick;
      if (pick == 2) begin
        m_we[i] = dmem_we[i]; m_sel[i] = dmem_be[i];
        m_adr[i] = dmem_adr[i]; m_dat[i] = dmem_wdat[i];
      end else begin
        m_we[i] = 1'b0; m_sel[i] = 4'hF;
        m_adr[i] = imem_adr[i]; m_dat[i] = '0;
      end
      if (rand_slave[i]) plan_slave(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(0);
    drive(1);
    @(negedge clk);
    step(0);
    step(1);
  endtask

  task automatic set_plan(int a0, int e0, int a1, int e1);
    ack_at[0] = a0; err_at[0] = e0;
    ack_at[1] = a1; err_at[1] = e1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rst_req[i] = 1'b1;
      req_i[i] = '0; req_d[i] = '0;
      reissue[i] = 1'b0; rand_req[i] = 1'b0; rand_slave[i] = 1'b0;
      stray_ack[i] = 1'b0; ack_at[i] = 0; err_at[i] = 0;
      owner[i] = 0; age[i] = 0; last[i] = 1;
      m_we[i] = 1'b0; m_sel[i] = '0; m_adr[i] = '0; m_dat[i] = '0;
      imem_stb[i] = 1'b0; imem_adr[i] = '0; dmem_stb[i] = 1'b0; dmem_we[i] = 1'b0;
      dmem_be[i] = '0; dmem_adr[i] = '0; dmem_wdat[i] = '0; wb_rdat[i] = '0;
      wb_ack[i] = 1'b0; wb_err[i] = 1'b0;
    end

    repeat (3) tick();
    rst_req[0] = 1'b0; rst_req[1] = 1'b0;
    repeat (2) tick();

    // Single fetch, slave acks in the third grant cycle.
    set_plan(3, 0, 3, 0);
    for (int i = 0; i < 2; i++) req_i[i] = '{1'b1, 1'b0, 4'hF, 32'h100, 32'h0};
    repeat (6) tick();

    // Simultaneous requests; dmem write wins on both instances.
    set_plan(2, 0, 2, 0);
    for (int i = 0; i < 2; i++) begin
      req_i[i] = '{1'b1, 1'b0, 4'hF, 32'h104, 32'h0};
      req_d[i] = '{1'b1, 1'b1, 4'h3, 32'h200, 32'h1234};
    end
    repeat (10) tick();

    // Both requesters held: u0 alternates D,I,D,I; u1 keeps serving dmem.
    set_plan(1, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      reissue[i] = 1'b1;
      req_i[i] = new_imem();
      req_d[i] = new_dmem();
    end
    repeat (8) tick();
    reissue[0] = 1'b0; reissue[1] = 1'b0;
    repeat (8) tick();

    // Silent slave: u0 watchdog errors in the 8th grant cycle.
    set_plan(0, 0, 3, 0);
    for (int i = 0; i < 2; i++) req_d[i] = new_dmem();
    repeat (12) tick();
    // Ack lands in the 8th cycle: ack wins over the watchdog.
    set_plan(8, 0, 3, 0);
    for (int i = 0; i < 2; i++) req_d[i] = new_dmem();
    repeat (12) tick();

    // ack and err together -> err only.
    set_plan(2, 2, 2, 2);
    for (int i = 0; i < 2; i++) req_i[i] = new_imem();
    repeat (6) tick();

    // Withdrawal in the second grant cycle, then a late ack while idle.
    set_plan(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) req_i[i] = new_imem();
    repeat (2) tick();
    req_i[0].stb = 1'b0; req_i[1].stb = 1'b0;
    tick();
    stray_ack[0] = 1'b1; stray_ack[1] = 1'b1;
    repeat (3) tick();

    // Reset during the third grant cycle, slave acks one cycle later.
    set_plan(4, 0, 4, 0);
    for (int i = 0; i < 2; i++) req_i[i] = new_imem();
    repeat (3) tick();
    rst_req[0] = 1'b1; rst_req[1] = 1'b1;
    tick();
    rst_req[0] = 1'b0; rst_req[1] = 1'b0;
    stray_ack[0] = 1'b1; stray_ack[1] = 1'b1;
    repeat (3) tick();

    // Randomised traffic.
    for (int i = 0; i < 2; i++) begin
      rand_req[i] = 1'b1; rand_slave[i] = 1'b1;
      ack_at[i] = $urandom_range(1, 4); err_at[i] = 0;
    end
    repeat (4000) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
